// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - byte-serial multi-precision add/sub sequencer for one external 8-bit adder
// Optional feature macro: ADDSEQ_ABORT_EN (adds abort input and result shadow copy)
module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
`ifdef ADDSEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  overflow,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic            sub_reg;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            last;
  logic            eff_b_msb;

`ifdef ADDSEQ_ABORT_EN
  logic [W-1:0]    shadow_result;
  logic            shadow_cout;
  logic            shadow_overflow;
`endif

  assign last      = (idx == IW'(NBYTES - 1));
  assign eff_b_msb = b_reg[W-1] ^ sub_reg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = 8'd0;
    add_b     = 8'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[{idx, 3'b000} +: 8];
        add_b   = b_reg[{idx, 3'b000} +: 8] ^ {8{sub_reg}};
        add_cin = carry;
`ifdef ADDSEQ_ABORT_EN
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
`else
        if (last) state_nxt = DONE;
`endif
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry chain: the seed carry of op_sub supplies the +1 of two's-complement subtraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
`ifdef ADDSEQ_ABORT_EN
      shadow_result   <= '0;
      shadow_cout     <= 1'b0;
      shadow_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            sub_reg <= op_sub;
            idx     <= '0;
            carry   <= op_sub;
`ifdef ADDSEQ_ABORT_EN
            shadow_result   <= result;
            shadow_cout     <= cout;
            shadow_overflow <= overflow;
`endif
          end
        end
        RUN: begin
`ifdef ADDSEQ_ABORT_EN
          if (abort) begin
            result   <= shadow_result;
            cout     <= shadow_cout;
            overflow <= shadow_overflow;
          end else
`endif
          begin
            result[{idx, 3'b000} +: 8] <= add_sum;
            carry                      <= add_cout;
            if (last) begin
              cout     <= add_cout;
              overflow <= (a_reg[W-1] == eff_b_msb) && (add_sum[7] != a_reg[W-1]);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - self-checking bench for adder_seq_ctrl with a behavioural reference model
// Build with ADDSEQ_ABORT_EN defined to also exercise the abort path.
module tb_adder_seq_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst, start, op_sub;
  logic [W-1:0]  a_in, b_in;
  logic          busy, done, cout, overflow;
  logic [W-1:0]  result;
  logic [7:0]    add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic [8:0]    sum9;
`ifdef ADDSEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational ripple adder.
  assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum  = sum9[7:0];
  assign add_cout = sum9[8];

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .a_in(a_in), .b_in(b_in),
`ifdef ADDSEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: whole-operand arithmetic, timed only by cycles since acceptance.
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_a, m_effb;
  logic         m_sub;
  logic [W-1:0] pend_res, vis_res;
  logic         pend_cout, pend_ovf, vis_cout, vis_ovf;

  always @(posedge clk) begin
    logic [W:0] full;
    if (rst) begin
      m_active = 1'b0; m_t = 0;
      vis_res = '0; vis_cout = 1'b0; vis_ovf = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_a       = a_in;
        m_sub     = op_sub;
        m_effb    = op_sub ? ~b_in : b_in;
        full      = {1'b0, m_a} + {1'b0, m_effb} + {{W{1'b0}}, m_sub};
        pend_res  = full[W-1:0];
        pend_cout = full[W];
        pend_ovf  = (m_a[W-1] == m_effb[W-1]) && (pend_res[W-1] != m_a[W-1]);
        m_active  = 1'b1;
        m_t       = 0;
      end
    end else begin
`ifdef ADDSEQ_ABORT_EN
      if (abort && m_t < NBYTES) m_active = 1'b0;
      else
`endif
      begin
        m_t++;
        if (m_t == NBYTES) begin
          vis_res = pend_res; vis_cout = pend_cout; vis_ovf = pend_ovf;
        end
        if (m_t == NBYTES + 1) m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] lowmask, partial;
    chk("busy", busy, m_active);
    chk("done", done, m_active && m_t == NBYTES);
    if (!m_active || m_t == NBYTES) begin
      chk("result", result, vis_res);
      chk("cout", cout, vis_cout);
      chk("overflow", overflow, vis_ovf);
      chk("adder_idle", {add_a, add_b, add_cin}, 17'd0);
    end else begin
      lowmask = (64'd1 << (8 * m_t)) - 64'd1;
      partial = (64'(m_a) & lowmask) + (64'(m_effb) & lowmask) + 64'(m_sub);
      chk("add_a", add_a, 8'(m_a >> (8 * m_t)));
      chk("add_b", add_b, 8'(m_effb >> (8 * m_t)));
      chk("add_cin", add_cin, partial[8 * m_t]);
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    start = 1'b1; a_in = a; b_in = b; op_sub = sub;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; n = i; end
    end
    chk("done_timeout", ok, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] er, input logic ec, input logic eo);
    int n; bit ok;
    start_op(a, b, sub);
    wait_done(n, ok);
    chk({name, "_latency"}, n, NBYTES + 1);
    chk({name, "_result"}, result, er);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, overflow, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int n; bit ok;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_adder", {add_a, add_b, add_cin}, 17'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ff_1",  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("sub_5_7",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_7_5",   32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Start while busy is ignored; a start right after done is accepted.
    start_op(32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'h01010101; op_sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, ok);
    chk("ignore_result", result, 32'h33333333);
    @(posedge clk); #1;
    run_op("b2b", 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0);

    // Reset during RUN at idx=2.
    start_op(32'h12345678, 32'h11111111, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_cout", cout, 1'b0);
    run_op("add_3_4", 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0);

`ifdef ADDSEQ_ABORT_EN
    run_op("add_1_1", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
    start_op(32'h00000010, 32'h00000020, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 32'h00000002);
    repeat (6) @(posedge clk);
    #1;
`endif

    // Randomized phase: stray starts, boundary operands, occasional reset/abort.
    for (int c = 0; c < 1500; c++) begin
      start  = ($urandom_range(0, 3) == 0);
      op_sub = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: a_in = 32'hFFFFFFFF;
        1: a_in = 32'h7FFFFFFF;
        default: a_in = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b_in = 32'h80000000;
        1: b_in = 32'h00000001;
        default: b_in = $urandom;
      endcase
      rst = ($urandom_range(0, 96) == 0);
`ifdef ADDSEQ_ABORT_EN
      abort = ($urandom_range(0, 19) == 0);
`endif
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0;
`ifdef ADDSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
